cpu_sequencer: RTL and testbench

Cycle sequencer for the 6502 core: tracks the T-state of the instruction in flight and tells the datapath when to fetch the next opcode, advance PC, perform memory writes and finish. It sits directly downstream of the opcode decoder: it consumes the decoder's `adr_mode`, `to_mem` and branch outputs, plus page-cross and branch-condition results from the datapath. It produces per-cycle phase and strobe signals that the datapath register enables are gated with.

---
 rtl/cpu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - 6502 T-state sequencer: cycle counter, instruction length and per-cycle strobes
//
// Tracks the cycle index of the instruction in flight and drives the datapath
// strobes that are gated with it.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   rdy           memory ready; low freezes all sequencer state for the cycle
//   adr_mode      decoder addressing mode (ADR_* codes below), valid from T1
//   to_mem        decoder store flag
//   page_cross    carry out of the effective-address low-byte add
//   branch_taken  branch condition true
//   t             current cycle index, 0 = opcode fetch
//   ir_load       latch opcode into IR at end of cycle
//   pc_inc        increment PC at end of cycle
//   write_cycle   this cycle is a bus write
//   last_cycle    final cycle of the instruction
//   jam           invalid opcode, CPU halted until reset
module cpu_sequencer #(
    parameter int T_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rdy,
    input  logic [4:0]     adr_mode,
    input  logic           to_mem,
    input  logic           page_cross,
    input  logic           branch_taken,
    output logic [T_W-1:0] t,
    output logic           ir_load,
    output logic           pc_inc,
    output logic           write_cycle,
    output logic           last_cycle,
    output logic           jam
);

    localparam logic [4:0] ADR_IMPL      = 5'd0;
    localparam logic [4:0] ADR_ACCUM     = 5'd1;
    localparam logic [4:0] ADR_IMM       = 5'd2;
    localparam logic [4:0] ADR_REL       = 5'd3;
    localparam logic [4:0] ADR_ZPG       = 5'd4;
    localparam logic [4:0] ADR_ABS_JMP   = 5'd5;
    localparam logic [4:0] ADR_STACK_PH  = 5'd6;
    localparam logic [4:0] ADR_ZPG_X_Y   = 5'd7;
    localparam logic [4:0] ADR_ABS       = 5'd8;
    localparam logic [4:0] ADR_ABS_X_Y   = 5'd9;
    localparam logic [4:0] ADR_STACK_PL  = 5'd10;
    localparam logic [4:0] ADR_ZPG_IND_Y = 5'd11;
    localparam logic [4:0] ADR_ABS_IND   = 5'd12;
    localparam logic [4:0] ADR_ZPG_RMW   = 5'd13;
    localparam logic [4:0] ADR_ABS_X_IND = 5'd14;
    localparam logic [4:0] ADR_ZPG_X_RMW = 5'd15;
    localparam logic [4:0] ADR_ABS_RMW   = 5'd16;
    localparam logic [4:0] ADR_ABS_JSR   = 5'd17;
    localparam logic [4:0] ADR_STACK_RTS = 5'd18;
    localparam logic [4:0] ADR_STACK_RTI = 5'd19;
    localparam logic [4:0] ADR_ABS_X_RMW = 5'd20;
    localparam logic [4:0] ADR_STACK_BRK = 5'd21;
    // 22 (ADR_INVAL) and every higher code halt the CPU.

    logic [T_W-1:0] t_q, t_d;
    logic [T_W-1:0] len_q, len_d;
    logic           jam_q, jam_d;

    logic [3:0]     base_len;
    logic           pc_t1, pc_t2, is_rmw, is_inval;
    logic [3:0]     len_sum;
    logic [T_W-1:0] len_eff;
    logic           inval_t1;

    // Per-mode base length and PC-increment profile.
    always_comb begin
        base_len = 4'd2;
        pc_t1    = 1'b1;
        pc_t2    = 1'b0;
        is_rmw   = 1'b0;
        is_inval = 1'b0;
        case (adr_mode)
            ADR_IMPL, ADR_ACCUM:                  begin base_len = 4'd2; pc_t1 = 1'b0; end
            ADR_IMM, ADR_REL:                     base_len = 4'd2;
            ADR_ZPG:                              base_len = 4'd3;
            ADR_ABS_JMP:                          begin base_len = 4'd3; pc_t2 = 1'b1; end
            ADR_STACK_PH:                         begin base_len = 4'd3; pc_t1 = 1'b0; end
            ADR_ZPG_X_Y:                          base_len = 4'd4;
            ADR_ABS, ADR_ABS_X_Y:                 begin base_len = 4'd4; pc_t2 = 1'b1; end
            ADR_STACK_PL:                         begin base_len = 4'd4; pc_t1 = 1'b0; end
            ADR_ZPG_IND_Y:                        base_len = 4'd5;
            ADR_ABS_IND:                          begin base_len = 4'd5; pc_t2 = 1'b1; end
            ADR_ZPG_RMW:                          begin base_len = 4'd5; is_rmw = 1'b1; end
            ADR_ABS_X_IND, ADR_ABS_JSR:           base_len = 4'd6;
            ADR_ZPG_X_RMW:                        begin base_len = 4'd6; is_rmw = 1'b1; end
            ADR_ABS_RMW:                          begin base_len = 4'd6; is_rmw = 1'b1; pc_t2 = 1'b1; end
            ADR_STACK_RTS, ADR_STACK_RTI:         begin base_len = 4'd6; pc_t1 = 1'b0; end
            ADR_ABS_X_RMW:                        begin base_len = 4'd7; is_rmw = 1'b1; pc_t2 = 1'b1; end
            ADR_STACK_BRK:                        begin base_len = 4'd7; pc_t1 = 1'b0; end
            default:                              is_inval = 1'b1;
        endcase
    end

    // Effective length for this cycle: the registered length plus any extension
    // sampled in this cycle, so last_cycle already reflects it. Inputs are live,
    // so a stalled sampling cycle effectively samples on the edge that leaves it.
    always_comb begin
        len_sum = {1'b0, 3'(len_q)};
        if (t_q == T_W'(1)) begin
            len_sum = base_len + {3'b0, (adr_mode == ADR_REL) & branch_taken};
        end else if (t_q == T_W'(2)) begin
            len_sum = {1'b0, 3'(len_q)}
                    + {3'b0, ((adr_mode == ADR_ABS_X_Y) & (page_cross | to_mem))
                           | ((adr_mode == ADR_REL) & page_cross)};
        end else if (t_q == T_W'(3)) begin
            len_sum = {1'b0, 3'(len_q)}
                    + {3'b0, (adr_mode == ADR_ZPG_IND_Y) & (page_cross | to_mem)};
        end
        len_eff = (len_sum > 4'd7) ? T_W'(7) : T_W'(len_sum);
    end

    always_comb begin
        inval_t1   = (t_q == T_W'(1)) & is_inval & ~jam_q;
        last_cycle = ~jam_q & ~inval_t1 & (t_q != '0) & (t_q == len_eff - T_W'(1));

        t_d   = t_q;
        len_d = len_q;
        jam_d = jam_q;
        if (rdy && !jam_q) begin
            len_d = len_eff;
            if (inval_t1) begin
                jam_d = 1'b1;
            end else if (last_cycle || t_q >= T_W'(6)) begin
                t_d = '0;
            end else begin
                t_d = t_q + T_W'(1);
            end
        end

        ir_load = rdy & ~jam_q & (t_q == '0);
        pc_inc  = rdy & ~jam_q & ((t_q == '0)
                                | ((t_q == T_W'(1)) & pc_t1)
                                | ((t_q == T_W'(2)) & pc_t2));

        // RMW: dummy write of the unmodified value, then the real write.
        write_cycle = ~jam_q & (t_q != '0) & (
                          (to_mem & last_cycle)
                        | (is_rmw & ((t_q == len_eff - T_W'(1)) | (t_q == len_eff - T_W'(2))))
                        | ((adr_mode == ADR_STACK_PH)  & (t_q == T_W'(2)))
                        | ((adr_mode == ADR_ABS_JSR)   & ((t_q == T_W'(3)) | (t_q == T_W'(4))))
                        | ((adr_mode == ADR_STACK_BRK) & (t_q >= T_W'(2)) & (t_q <= T_W'(4))));

        t   = t_q;
        jam = jam_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q   <= '0;
            len_q <= T_W'(2);
            jam_q <= 1'b0;
        end else begin
            t_q   <= t_d;
            len_q <= len_d;
            jam_q <= jam_d;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed and randomized bench for cpu_sequencer against a length/strobe model
module tb_cpu_sequencer;

    localparam int M_IMPL = 0,  M_ACCUM = 1,  M_IMM = 2,  M_REL = 3,  M_ZPG = 4;
    localparam int M_ABS_JMP = 5, M_PH = 6, M_ZPG_X_Y = 7, M_ABS = 8, M_ABS_X_Y = 9;
    localparam int M_PL = 10, M_IND_Y = 11, M_ABS_IND = 12, M_ZPG_RMW = 13, M_ABS_X_IND = 14;
    localparam int M_ZPG_X_RMW = 15, M_ABS_RMW = 16, M_JSR = 17, M_RTS = 18, M_RTI = 19;
    localparam int M_ABS_X_RMW = 20, M_BRK = 21, M_INVAL = 22;

    // Total cycles per mode, fetch included.
    int base_tbl [22] = '{2,2,2,2,3,3,3,4,4,4,4,5,5,5,6,6,6,6,6,6,7,7};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rdy;
    logic [4:0] adr_mode;
    logic       to_mem;
    logic       page_cross;
    logic       branch_taken;
    logic [2:0] t;
    logic       ir_load, pc_inc, write_cycle, last_cycle, jam;

    int errors = 0;
    int checks = 0;

    cpu_sequencer #(.T_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .adr_mode(adr_mode), .to_mem(to_mem),
        .page_cross(page_cross), .branch_taken(branch_taken), .t(t), .ir_load(ir_load),
        .pc_inc(pc_inc), .write_cycle(write_cycle), .last_cycle(last_cycle), .jam(jam)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit pc_model(input int mode, input int k);
        bit no_t1, t2;
        no_t1 = (mode == M_IMPL) || (mode == M_ACCUM) || (mode == M_PH) || (mode == M_PL)
             || (mode == M_RTS) || (mode == M_RTI) || (mode == M_BRK);
        t2 = (mode == M_ABS) || (mode == M_ABS_RMW) || (mode == M_ABS_X_Y)
          || (mode == M_ABS_X_RMW) || (mode == M_ABS_IND) || (mode == M_ABS_JMP);
        return (k == 0) || (k == 1 && !no_t1) || (k == 2 && t2);
    endfunction

    function automatic bit wr_model(input int mode, input bit tm, input int len, input int k);
        bit rmw;
        rmw = (mode == M_ZPG_RMW) || (mode == M_ZPG_X_RMW) || (mode == M_ABS_RMW) || (mode == M_ABS_X_RMW);
        if (k == 0) return 1'b0;
        return (tm && k == len - 1) || (rmw && k >= len - 2) || (mode == M_PH && k == 2)
            || (mode == M_JSR && (k == 3 || k == 4)) || (mode == M_BRK && k >= 2 && k <= 4);
    endfunction

    // pcf: -1 random page_cross per cycle, else forced value.
    // exp_cycles: when nonzero, cycles (stalls included) until the DUT's final advance.
    task automatic run_instr(input int mode, input bit tm, input bit taken, input int pcf,
                             input int stall_t, input int stall_n, input int exp_cycles);
        bit pcs [8];
        int len, nst, cyc, obs_cyc;
        for (int i = 0; i < 8; i++) pcs[i] = (pcf < 0) ? 1'($urandom) : 1'(pcf);
        len = base_tbl[mode];
        if (mode == M_ABS_X_Y && (pcs[2] || tm)) len++;
        if (mode == M_IND_Y && (pcs[3] || tm)) len++;
        if (mode == M_REL && taken) begin
            len++;
            if (pcs[2]) len++;
        end
        cyc = 0;
        obs_cyc = 0;
        for (int k = 0; k < len; k++) begin
            nst = (k == stall_t) ? stall_n : 0;
            for (int s = 0; s <= nst; s++) begin
                @(negedge clk);
                rdy = (s == nst);
                if (k == 0) begin
                    adr_mode     = 5'($urandom);
                    to_mem       = 1'($urandom);
                    page_cross   = 1'($urandom);
                    branch_taken = 1'($urandom);
                end else begin
                    adr_mode     = 5'(mode);
                    to_mem       = tm;
                    page_cross   = pcs[k];
                    branch_taken = taken;
                end
                #1;
                cyc++;
                chk("t", 8'(t), 8'(k));
                chk("jam", 8'(jam), 8'd0);
                chk("ir_load", 8'(ir_load), 8'(rdy && k == 0));
                chk("pc_inc", 8'(pc_inc), 8'(rdy && pc_model(mode, k)));
                chk("write_cycle", 8'(write_cycle), 8'(wr_model(mode, tm, len, k)));
                chk("last_cycle", 8'(last_cycle), 8'(k == len - 1));
                if (rdy && last_cycle && obs_cyc == 0) obs_cyc = cyc;
            end
        end
        if (exp_cycles != 0) chk("instr_cycles", 8'(obs_cyc), 8'(exp_cycles));
    endtask

    initial begin
        rst_n = 1'b0;
        rdy = 1'($urandom);
        adr_mode = 5'd0; to_mem = 1'b0; page_cross = 1'b0; branch_taken = 1'b0;
        #2;
        chk("rst_t", 8'(t), 8'd0);
        chk("rst_jam", 8'(jam), 8'd0);
        chk("rst_write", 8'(write_cycle), 8'd0);
        chk("rst_last", 8'(last_cycle), 8'd0);
        chk("rst_ir_load", 8'(ir_load), 8'(rdy));
        chk("rst_pc_inc", 8'(pc_inc), 8'(rdy));
        @(posedge clk); #1 rst_n = 1'b1;

        run_instr(M_IMM, 0, 0, -1, -1, 0, 2);
        run_instr(M_ABS_X_Y, 0, 0, 0, -1, 0, 4);
        run_instr(M_ABS_X_Y, 0, 0, 1, -1, 0, 5);
        run_instr(M_ABS_X_Y, 1, 0, 0, -1, 0, 5);
        run_instr(M_REL, 0, 0, 1, -1, 0, 2);
        run_instr(M_REL, 0, 1, 0, -1, 0, 3);
        run_instr(M_REL, 0, 1, 1, -1, 0, 4);
        run_instr(M_ABS_X_RMW, 0, 0, -1, -1, 0, 7);
        run_instr(M_BRK, 0, 0, -1, -1, 0, 7);
        run_instr(M_ZPG_RMW, 0, 0, -1, 2, 3, 8);
        run_instr(M_IND_Y, 0, 0, 1, 3, 2, 8);
        run_instr(M_JSR, 0, 0, -1, -1, 0, 6);
        run_instr(M_PH, 0, 0, -1, 0, 1, 4);

        for (int n = 0; n < 40; n++) begin
            run_instr(int'($urandom_range(0, 21)), 1'($urandom), 1'($urandom), -1,
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 0);
        end

        // Invalid opcode: fetch, then an invalid mode at T1 halts the sequencer.
        @(negedge clk);
        rdy = 1'b1; adr_mode = 5'($urandom);
        #1 chk("jam_t0", 8'(t), 8'd0);
        @(negedge clk);
        adr_mode = 5'($urandom_range(M_INVAL, 31));
        #1 chk("jam_t1", 8'(t), 8'd1);
        chk("jam_pre", 8'(jam), 8'd0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            rdy = 1'($urandom); adr_mode = 5'($urandom); to_mem = 1'($urandom);
            page_cross = 1'($urandom); branch_taken = 1'($urandom);
            #1;
            chk("jammed_jam", 8'(jam), 8'd1);
            chk("jammed_t", 8'(t), 8'd1);
            chk("jammed_strobes", {4'd0, ir_load, pc_inc, write_cycle, last_cycle}, 8'd0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_t", 8'(t), 8'd0);
        chk("async_rst_jam", 8'(jam), 8'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_instr(M_IMM, 0, 0, -1, -1, 0, 2);
        run_instr(M_ZPG, 1, 0, -1, -1, 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
